// File: rtl/spi_ram_burst_slave.sv
// rtl/spi_ram_burst_slave.sv - SPI slave command decoder with burst access to an internal RAM
module spi_ram_burst_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic MOSI,
  output logic MISO,
  output logic addr_err
);

  // The input shifter only holds the leading bits; the last bit comes straight from MOSI.
  localparam int SHIFT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(SHIFT_W) + 1;
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W    = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WR_ADDR = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_RD_ADDR = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  logic [2:0]            state;
  logic [SHIFT_W-2:0]    shift;
  logic [CNT_W-1:0]      cnt;
  logic                  cmd_hi;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] out_shift;
  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  addr_in_oor;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;

  // Out-of-range addresses (including MEM_DEPTH-1 itself) roll over to 0.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if ({1'b0, a} >= LAST_W) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  // Assemble the completed word from the shifter plus the bit being sampled now.
  always_comb begin
    addr_in     = {shift[ADDR_WIDTH-2:0], MOSI};
    data_in     = {shift[DATA_WIDTH-2:0], MOSI};
    addr_in_oor = ({1'b0, addr_in} >= DEPTH_W);
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    rd_word     = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
    wr_en       = !ss_n && (state == S_WR_DATA) && (cnt == DATA_LAST) && wr_in_range;
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W-1:0]] <= data_in;
  end

  // Command decode, address registers, and the gapless read serialiser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift     <= '0;
      cnt       <= '0;
      cmd_hi    <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      out_shift <= '0;
      MISO      <= 1'b0;
      addr_err  <= 1'b0;
    end else if (ss_n) begin
      state <= S_IDLE;
      shift <= '0;
      cnt   <= '0;
      MISO  <= 1'b0;
    end else begin
      MISO <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_CMD;
          cnt   <= '0;
        end
        S_CMD: begin
          if (cnt == '0) begin
            cmd_hi <= MOSI;
            cnt    <= CNT_W'(1);
          end else begin
            cnt   <= '0;
            shift <= '0;
            case ({cmd_hi, MOSI})
              2'b00:   state <= S_WR_ADDR;
              2'b01:   state <= S_WR_DATA;
              2'b10:   state <= S_RD_ADDR;
              default: state <= S_RD_DATA;
            endcase
          end
        end
        S_WR_ADDR, S_RD_ADDR: begin
          shift <= {shift[SHIFT_W-3:0], MOSI};
          if (cnt == ADDR_LAST) begin
            if (state == S_WR_ADDR) wr_addr <= addr_in;
            else                    rd_addr <= addr_in;
            if (addr_in_oor) addr_err <= 1'b1;
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WR_DATA: begin
          shift <= {shift[SHIFT_W-3:0], MOSI};
          if (cnt == DATA_LAST) begin
            wr_addr <= next_addr(wr_addr);
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RD_DATA: begin
          if (cnt == '0) begin
            MISO      <= rd_word[DATA_WIDTH-1];
            out_shift <= rd_word << 1;
            rd_addr   <= next_addr(rd_addr);
            cnt       <= CNT_W'(1);
          end else begin
            MISO      <= out_shift[DATA_WIDTH-1];
            out_shift <= out_shift << 1;
            cnt       <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          state <= S_DRAIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb/tb_spi_ram_burst_slave.sv - directed bench for spi_ram_burst_slave
module tb_spi_ram_burst_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss_n_a;
  logic        ss_n_b;
  logic        mosi;
  logic        miso_a;
  logic        miso_b;
  logic        err_a;
  logic        err_b;
  int          sel;
  int          passed;
  int          total;
  logic [31:0] v;
  logic        pre;

  always #5 clk = ~clk;

  spi_ram_burst_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .ss_n(ss_n_a), .MOSI(mosi), .MISO(miso_a), .addr_err(err_a)
  );

  spi_ram_burst_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)) dut_b (
    .clk(clk), .rst(rst), .ss_n(ss_n_b), .MOSI(mosi), .MISO(miso_b), .addr_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_ss(input logic val);
    if (sel == 0) ss_n_a = val;
    else          ss_n_b = val;
  endtask

  function automatic logic miso_sel();
    return (sel == 0) ? miso_a : miso_b;
  endfunction

  task automatic start_cmd(input logic [1:0] cmd);
    @(negedge clk); set_ss(1'b0); mosi = 1'b0;
    @(negedge clk); mosi = cmd[1];
    @(negedge clk); mosi = cmd[0];
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); mosi = val[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk); set_ss(1'b1); mosi = 1'b0;
  endtask

  task automatic write_addr(input logic [7:0] a);
    start_cmd(2'b00); send_bits({24'd0, a}, 8); end_frame();
  endtask

  task automatic set_raddr(input logic [7:0] a);
    start_cmd(2'b10); send_bits({24'd0, a}, 8); end_frame();
  endtask

  task automatic write_data(input logic [31:0] val, input int nbytes);
    start_cmd(2'b01); send_bits(val, 8 * nbytes); end_frame();
  endtask

  // Samples MISO after E2 (gap), then after E3..E3+n-1; raises ss_n before E3+n.
  task automatic read_data(input int n, output logic [31:0] val, output logic gap);
    start_cmd(2'b11);
    @(negedge clk);
    gap = miso_sel();
    val = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      val = {val[30:0], miso_sel()};
    end
    set_ss(1'b1); mosi = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0; sel = 0;
    rst = 1'b1; ss_n_a = 1'b1; ss_n_b = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_miso_a", 32'(miso_a), 32'h0);
    check("reset_err_a",  32'(err_a),  32'h0);
    check("reset_miso_b", 32'(miso_b), 32'h0);
    check("reset_err_b",  32'(err_b),  32'h0);

    // Single word write then read back.
    sel = 0;
    write_addr(8'h10);
    write_data(32'hA5, 1);
    set_raddr(8'h10);
    read_data(8, v, pre);
    check("t1_miso_before_e3", 32'(pre), 32'h0);
    check("t1_read_a5", v, 32'hA5);
    check("t1_addr_err", 32'(err_a), 32'h0);

    // Burst write across the top of memory, then one more word to probe wr_addr.
    write_addr(8'hFE);
    write_data(32'h112233, 3);
    write_data(32'h44, 1);

    // Gapless burst read across the wrap, then continue from rd_addr.
    set_raddr(8'hFE);
    read_data(24, v, pre);
    check("t3_burst_read", v, 32'h112233);
    @(negedge clk);
    check("t3_miso_after_frame", 32'(miso_a), 32'h0);
    read_data(8, v, pre);
    check("t3_rd_addr_01", v, 32'h44);

    // Aborted data word, aborted address, aborted command.
    write_addr(8'h20);
    write_data(32'h5A, 1);
    start_cmd(2'b01); send_bits(32'h16, 5); end_frame();
    @(negedge clk);
    check("t4_abort_miso", 32'(miso_a), 32'h0);
    write_data(32'hC3, 1);
    start_cmd(2'b00); send_bits(32'h5, 4); end_frame();
    @(negedge clk); set_ss(1'b0); mosi = 1'b0;
    @(negedge clk); mosi = 1'b0;
    @(negedge clk); set_ss(1'b1); mosi = 1'b1;
    write_data(32'h99, 1);
    set_raddr(8'h20);
    read_data(24, v, pre);
    check("t4_after_aborts", v, 32'h5AC399);

    // Depth-200 instance: out-of-range handling and wrap at 199.
    sel = 1;
    write_addr(8'hD0);
    check("t5_addr_err_set", 32'(err_b), 32'h1);
    check("t5_other_err_clear", 32'(err_a), 32'h0);
    write_data(32'h77, 1);
    write_data(32'h66, 1);
    set_raddr(8'hD0);
    read_data(8, v, pre);
    check("t5_oor_read_zero", v, 32'h0);
    set_raddr(8'h05);
    check("t5_addr_err_sticky", 32'(err_b), 32'h1);
    set_raddr(8'h00);
    read_data(8, v, pre);
    check("t5_oor_wr_wrapped_to_0", v, 32'h66);
    write_addr(8'hC7);
    write_data(32'hABCD, 2);
    set_raddr(8'hC7);
    read_data(16, v, pre);
    check("t5_wrap_at_199", v, 32'hABCD);

    // Asynchronous reset in the middle of a read burst.
    sel = 0;
    set_raddr(8'hFE);
    start_cmd(2'b11);
    @(negedge clk);
    v = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      v = {v[30:0], miso_a};
    end
    check("t6_partial_stream", v, 32'h089);
    #2;
    rst = 1'b1; ss_n_a = 1'b1; ss_n_b = 1'b1;
    #1;
    check("t6_rst_miso", 32'(miso_a), 32'h0);
    check("t6_rst_err_b", 32'(err_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    write_data(32'h3C, 1);
    read_data(8, v, pre);
    check("t6_addr_regs_reset", v, 32'h3C);
    set_raddr(8'h10);
    read_data(8, v, pre);
    check("t6_ram_retained", v, 32'hA5);
    sel = 1;
    set_raddr(8'hC7);
    read_data(8, v, pre);
    check("t6_ram_b_retained", v, 32'hAB);
    check("t6_err_b_after_valid", 32'(err_b), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
